// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU interface and the nibble sequencer.
// Holds the nibble width, the mode/select encodings (identical to the
// external ALU's) and the sequencer state type.
package alu_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic MODE_LOGIC = 1'b0;
  localparam logic MODE_ARITH = 1'b1;

  // Logic-mode selects (M = 0)
  localparam logic [1:0] S_NOT = 2'b00;
  localparam logic [1:0] S_AND = 2'b01;
  localparam logic [1:0] S_OR  = 2'b10;
  localparam logic [1:0] S_XOR = 2'b11;

  // Arithmetic-mode selects (M = 1); 2'b1x are unsupported by the ALU
  localparam logic [1:0] S_ADD = 2'b00;
  localparam logic [1:0] S_SUB = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_t;

endpackage

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
//   Takes one WIDTH-bit ALU request, drives it through an external 4-bit ALU
//   one nibble per cycle (LSB first, carry/borrow chained between nibbles)
//   and returns the assembled result.
//
//   state | meaning
//   IDLE  | req_ready=1, waiting for a request
//   RUN   | issuing nibble idx to the ALU, capturing F/Cn each edge
//   DONE  | rsp_valid=1, holding result until rsp_ready
//
// Ports:
//   clk_i/rst_i-style naming is fixed by the interface: clk, rst (async, high)
//   req_*  : request handshake and operands (m, s, a, b, cin)
//   alu_*  : nibble operands to / combinational response from the ALU
//   rsp_*  : response handshake, WIDTH-bit result and final carry/borrow
module alu_nibble_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_m,
  input  logic [1:0]       req_s,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_cin,
  output logic [1:0]       alu_s,
  output logic             alu_m,
  input  logic [3:0]       alu_f,
  input  logic             alu_cn,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_cn
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             m_q, m_d;
  logic [1:0]       s_q, s_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      m_q     <= 1'b0;
      s_q     <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      m_q     <= m_d;
      s_q     <= s_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    m_d       = m_q;
    s_d       = s_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_f     = '0;
    rsp_cn    = 1'b0;
    alu_a     = 4'h0;
    alu_b     = 4'h0;
    alu_cin   = 1'b0;
    alu_s     = 2'b00;
    alu_m     = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          m_d     = req_m;
          s_d     = req_s;
          a_d     = req_a;
          b_d     = req_b;
          idx_d   = '0;
          // Logic ops never consume a carry, so drop req_cin up front.
          carry_d = (req_m == MODE_ARITH) ? req_cin : 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        alu_a   = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
        alu_b   = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
        alu_cin = (m_q == MODE_ARITH) ? carry_q : 1'b0;
        alu_s   = s_q;
        alu_m   = m_q;
        res_d[NIBBLE_W*idx_q +: NIBBLE_W] = alu_f;
        carry_d = alu_cn;
        if (idx_q == IDX_LAST) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end

      DONE: begin
        rsp_valid = 1'b1;
        rsp_f     = res_q;
        rsp_cn    = carry_q;
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
module tb_alu_nibble_sequencer;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_m, req_cin;
  logic [1:0]   req_s;
  logic [W-1:0] req_a, req_b;
  logic [3:0]   alu_a, alu_b, alu_f;
  logic         alu_cin, alu_m, alu_cn;
  logic [1:0]   alu_s;
  logic         rsp_valid, rsp_ready, rsp_cn;
  logic [W-1:0] rsp_f;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_m(req_m), .req_s(req_s),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_s(alu_s), .alu_m(alu_m),
    .alu_f(alu_f), .alu_cn(alu_cn),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f), .rsp_cn(rsp_cn)
  );

  // Behavioural external 4-bit ALU
  always_comb begin
    logic [4:0] t;
    t      = 5'd0;
    alu_f  = 4'h0;
    alu_cn = 1'b0;
    if (alu_m) begin
      if (alu_s == 2'b00) t = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
      else if (alu_s == 2'b01) t = {1'b0, alu_a} - {1'b0, alu_b} - {4'b0, alu_cin};
      alu_f  = t[3:0];
      alu_cn = t[4];
    end else begin
      case (alu_s)
        2'b00: alu_f = ~alu_a;
        2'b01: alu_f = alu_a & alu_b;
        2'b10: alu_f = alu_a | alu_b;
        default: alu_f = alu_a ^ alu_b;
      endcase
    end
  end

  // Whole-word reference model
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic m, input logic [1:0] s,
                                 output logic [W-1:0] f, output logic cn);
    logic [W:0] t;
    t = '0;
    f = '0;
    cn = 1'b0;
    if (m) begin
      if (s == 2'b00) t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      else if (s == 2'b01) t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
      f  = t[W-1:0];
      cn = t[W];
    end else begin
      case (s)
        2'b00: f = ~a;
        2'b01: f = a & b;
        2'b10: f = a | b;
        default: f = a ^ b;
      endcase
    end
  endfunction

  // Drives one request and collects observations (no checking here).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic m, input logic [1:0] s,
                       output logic [W-1:0] f, output logic cn,
                       output int lat, output logic [NIB-1:0] cins);
    int guard;
    guard = 0;
    cins = '0;
    @(posedge clk); #1;
    while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    req_valid = 1'b1; req_a = a; req_b = b; req_cin = cin; req_m = m; req_s = s;
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      if (lat < NIB) cins[lat] = alu_cin;
      @(posedge clk); #1;
      lat++;
    end
    f  = rsp_f;
    cn = rsp_cn;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_hs: req_ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid);
    end
    n_tests++;
    if (rsp_f !== '0 || rsp_cn !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp: rsp_f=%h rsp_cn=%b want 0 0", rsp_f, rsp_cn);
    end
    n_tests++;
    if ({alu_a, alu_b, alu_cin, alu_s, alu_m} !== '0) begin
      n_fail++; $display("FAIL reset_alu: a=%h b=%h cin=%b s=%b m=%b want all 0",
                         alu_a, alu_b, alu_cin, alu_s, alu_m);
    end
  endtask

  task automatic test_add;
    logic [W-1:0] f; logic cn; int lat; logic [NIB-1:0] cins;
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b1, 2'b00, f, cn, lat, cins);
    n_tests++;
    if (f !== 16'h0100 || cn !== 1'b0) begin
      n_fail++; $display("FAIL add_basic: f=%h cn=%b want 0100 0", f, cn);
    end
    n_tests++;
    if (lat !== NIB) begin
      n_fail++; $display("FAIL add_latency: %0d cycles want %0d", lat, NIB);
    end
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b1, 2'b00, f, cn, lat, cins);
    n_tests++;
    if (f !== 16'h0000 || cn !== 1'b1) begin
      n_fail++; $display("FAIL add_ripple: f=%h cn=%b want 0000 1", f, cn);
    end
    n_tests++;
    if (cins !== 4'b1111) begin
      n_fail++; $display("FAIL add_ripple_cin: cins=%b want 1111", cins);
    end
  endtask

  task automatic test_sub;
    logic [W-1:0] f; logic cn; int lat; logic [NIB-1:0] cins;
    do_op(16'h0000, 16'h0001, 1'b0, 1'b1, 2'b01, f, cn, lat, cins);
    n_tests++;
    if (f !== 16'hFFFF || cn !== 1'b1) begin
      n_fail++; $display("FAIL sub_borrow: f=%h cn=%b want ffff 1", f, cn);
    end
    do_op(16'h1234, 16'h0234, 1'b0, 1'b1, 2'b01, f, cn, lat, cins);
    n_tests++;
    if (f !== 16'h1000 || cn !== 1'b0) begin
      n_fail++; $display("FAIL sub_noborrow: f=%h cn=%b want 1000 0", f, cn);
    end
  endtask

  task automatic test_logic;
    logic [W-1:0] f; logic cn; int lat; logic [NIB-1:0] cins;
    do_op(16'hA5A5, 16'hFFFF, 1'b1, 1'b0, 2'b11, f, cn, lat, cins);
    n_tests++;
    if (f !== 16'h5A5A || cn !== 1'b0) begin
      n_fail++; $display("FAIL logic_xor: f=%h cn=%b want 5a5a 0", f, cn);
    end
    n_tests++;
    if (cins !== 4'b0000) begin
      n_fail++; $display("FAIL logic_cin: cins=%b want 0000", cins);
    end
    do_op(16'hA5A5, 16'h1234, 1'b1, 1'b0, 2'b00, f, cn, lat, cins);
    n_tests++;
    if (f !== 16'h5A5A || cn !== 1'b0 || cins !== 4'b0000) begin
      n_fail++; $display("FAIL logic_not: f=%h cn=%b cins=%b want 5a5a 0 0000", f, cn, cins);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, f, ef; logic cin, m, cn, ecn; logic [1:0] s;
    int lat; logic [NIB-1:0] cins;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom); b = W'($urandom);
      cin = 1'($urandom); m = 1'($urandom); s = 2'($urandom_range(0, 3));
      ref_op(a, b, cin, m, s, ef, ecn);
      do_op(a, b, cin, m, s, f, cn, lat, cins);
      n_tests++;
      if (f !== ef || cn !== ecn || lat !== NIB) begin
        n_fail++;
        $display("FAIL rand_%0d: a=%h b=%h cin=%b m=%b s=%b got f=%h cn=%b lat=%0d want f=%h cn=%b lat=%0d",
                 i, a, b, cin, m, s, f, cn, lat, ef, ecn, NIB);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] f; logic cn; int lat; bit ok;
    @(posedge clk); #1;
    req_valid = 1'b1; req_a = 16'h0F0F; req_b = 16'h0101; req_cin = 1'b1; req_m = 1'b1; req_s = 2'b00;
    @(posedge clk); #1;
    // Second request stays pending on the bus from here on.
    req_a = 16'h1111; req_b = 16'h2222; req_cin = 1'b0; req_m = 1'b1; req_s = 2'b00;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_f !== 16'h1011 || rsp_cn !== 1'b0) begin
      n_fail++; $display("FAIL bp_first: valid=%b f=%h cn=%b want 1 1011 0", rsp_valid, rsp_f, rsp_cn);
    end
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_f !== 16'h1011 || rsp_cn !== 1'b0 || req_ready !== 1'b0 ||
          {alu_a, alu_b, alu_cin, alu_s, alu_m} !== '0) ok = 1'b0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL bp_hold: valid=%b f=%h cn=%b req_ready=%b want 1 1011 0 0 held",
                         rsp_valid, rsp_f, rsp_cn, req_ready);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: valid=%b req_ready=%b want 0 1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_accept: req_ready=%b want 0", req_ready);
    end
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    f = rsp_f; cn = rsp_cn;
    n_tests++;
    if (f !== 16'h3333 || cn !== 1'b0 || lat !== NIB) begin
      n_fail++; $display("FAIL bp_second: f=%h cn=%b lat=%0d want 3333 0 %0d", f, cn, lat, NIB);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] f; logic cn; int lat; logic [NIB-1:0] cins; bit seen;
    @(posedge clk); #1;
    req_valid = 1'b1; req_a = 16'hFFFF; req_b = 16'h0001; req_cin = 1'b0; req_m = 1'b1; req_s = 2'b00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_f !== '0 || rsp_cn !== 1'b0 ||
        {alu_a, alu_b, alu_cin, alu_s, alu_m} !== '0) begin
      n_fail++; $display("FAIL rst_mid: req_ready=%b valid=%b f=%h cn=%b alu_a=%h want 1 0 0 0 0",
                         req_ready, rsp_valid, rsp_f, rsp_cn, alu_a);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    n_tests++;
    if (seen) begin
      n_fail++; $display("FAIL rst_no_rsp: rsp_valid pulsed=1 want 0");
    end
    do_op(16'h8000, 16'h8000, 1'b1, 1'b1, 2'b00, f, cn, lat, cins);
    n_tests++;
    if (f !== 16'h0001 || cn !== 1'b1 || lat !== NIB) begin
      n_fail++; $display("FAIL rst_after: f=%h cn=%b lat=%0d want 0001 1 %0d", f, cn, lat, NIB);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_m = 1'b0; req_s = 2'b00; req_a = '0; req_b = '0; req_cin = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_add;
    test_sub;
    test_logic;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Initiator side of the 4-bit ALU operation interface (A, B, Cin, S, M in; F, Cn out).
- Accepts one WIDTH-bit operation request over a valid/ready handshake.
- Issues it to the external 4-bit ALU one nibble per cycle, LSB nibble first, chaining carry/borrow between nibbles.
- Assembles the WIDTH-bit result and returns it over a second valid/ready handshake.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibble steps (derived; not overridable).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_m  input  1  mode: 0 logic, 1 arithmetic.
- req_s  input  2  function select; same encoding as the ALU.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- req_cin  input  1  carry-in (add) or borrow-in (sub).
- alu_a  output  4  ALU A nibble.
- alu_b  output  4  ALU B nibble.
- alu_cin  output  1  ALU Cin.
- alu_s  output  2  ALU S.
- alu_m  output  1  ALU M.
- alu_f  input  4  ALU F, combinational response.
- alu_cn  input  1  ALU Cn, combinational response.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_f  output  WIDTH  assembled result.
- rsp_cn  output  1  final carry-out / borrow-out.

Behaviour:
- Reset: state=IDLE, idx=0, all operand/result/carry registers 0. Outputs: req_ready=1, rsp_valid=0, rsp_f=0, rsp_cn=0, all alu_* = 0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch m, s, a, b; set idx=0 and carry=req_cin if req_m=1, else carry=0. Go to RUN.
- RUN:
  - req_ready=0.
  - alu_a = a[4*idx +: 4], alu_b = b[4*idx +: 4], alu_cin = carry, alu_s = s, alu_m = m. All driven from registers only, with no combinational path from req_*.
  - Each edge: result[4*idx +: 4] <= alu_f; carry <= alu_cn.
  - If idx == NIB-1, go to DONE; otherwise idx <= idx+1.
- DONE:
  - rsp_valid=1, rsp_f = result, rsp_cn = carry.
  - Outputs stay stable while rsp_ready=0.
  - On rsp_ready=1, go to IDLE.
  - req_ready=0, so no new request is accepted in the same cycle.
- alu_* outputs are 0 in IDLE and DONE.
- Latency: request accepted at edge E; rsp_valid rises at edge E+NIB. Throughput is one operation per NIB+2 cycles with rsp_ready held high.
- Arithmetic chaining:
  - Add (m=1, s=00): the ALU computes {Cn,F} = A+B+Cin per nibble. The final Cn is the WIDTH-bit carry-out.
  - Sub (m=1, s=01): the ALU computes {Cn,F} = A-B-Cin. Cn=1 means borrow, and it is fed forward as the next nibble's Cin. The final rsp_cn=1 means a - b - req_cin < 0 (unsigned).
- Logic mode (m=0): alu_cin forced 0 every step. The ALU returns Cn=0, so rsp_cn=0. NOT (s=00) operates on A only, and the B nibble is still driven.
- Unsupported arithmetic selects (m=1, s=1x): sequenced normally; the ALU returns 0, so rsp_f=0 and rsp_cn=0. No error flag.
- req_valid while not in IDLE: ignored. The requester must hold its request until req_ready=1.
- Reset mid-RUN or mid-DONE: return immediately to reset values. The in-flight operation is discarded and no response is produced.
- No overflow/sign flag. Signed interpretation is left to the consumer.

Decomposition:
- Shared package (alu_pkg):
  - NIBBLE_W=4.
  - Mode constants MODE_LOGIC=0, MODE_ARITH=1.
  - Select constants: S_NOT/S_AND/S_OR/S_XOR for logic, S_ADD/S_SUB for arithmetic.
  - seq_state_t enum {IDLE, RUN, DONE}.
- No sub-module inside the sequencer; the 4-bit ALU is instantiated alongside it at the parent level and connected via the alu_* ports.

Test Plan:
- Add, no carry-out: a=16'h00FF, b=16'h0001, cin=0, m=1, s=00 -> rsp_f=16'h0100, rsp_cn=0; rsp_valid exactly 4 cycles after acceptance.
- Add, ripple through every nibble: a=16'hFFFF, b=16'h0000, cin=1 -> rsp_f=16'h0000, rsp_cn=1; alu_cin observed as 1,1,1,1 across the four steps.
- Sub with borrow: a=16'h0000, b=16'h0001, cin=0, m=1, s=01 -> rsp_f=16'hFFFF, rsp_cn=1. Also a=16'h1234, b=16'h0234 -> 16'h1000, rsp_cn=0.
- Logic: a=16'hA5A5, b=16'hFFFF, m=0, s=11 -> rsp_f=16'h5A5A. With s=00 -> rsp_f=16'h5A5A and b ignored. alu_cin=0 on all steps and rsp_cn=0.
- Backpressure: complete an add, hold rsp_ready=0 for 3 cycles -> rsp_valid/rsp_f/rsp_cn stable, req_ready=0, and a pending req_valid is not accepted until the cycle after the handshake.
- Reset mid-operation: assert rst after 2 RUN steps -> outputs return to reset values, no rsp_valid pulse. A subsequent request completes correctly.
